// File: rtl/dram_responder.sv
// Block-granular external memory responder: accepts one read/write request,
// holds it for a fixed latency, then performs the access and pulses ack for one cycle.
module dram_responder #(
    parameter int data_width  = 256,
    parameter int mem_size    = 2048,
    parameter int delay       = 10,
    parameter int addr_width  = 32,
    parameter int offset_bits = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cs_i,
    input  logic                  we_i,
    input  logic [addr_width-1:0] addr_i,
    input  logic [data_width-1:0] data_i,
    output logic                  ack_o,
    output logic [data_width-1:0] data_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int DLY    = (delay < 1) ? 1 : delay;
    localparam int CNT_W  = $clog2(DLY + 1);
    localparam int IDX_W  = addr_width - offset_bits;
    localparam int MEM_AW = (mem_size > 1) ? $clog2(mem_size) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_count;
    logic                  r_we;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;
    logic [data_width-1:0] r_wdata;
    logic [data_width-1:0] r_rdata;
    logic [data_width-1:0] r_mem [mem_size];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_inRange;
    logic [MEM_AW-1:0]     w_memAddr;
    logic                  w_unusedOffset;

    assign w_inRange      = (r_idx < IDX_W'(mem_size));
    assign w_memAddr      = r_idx[MEM_AW-1:0];
    assign w_unusedOffset = ^addr_i[offset_bits-1:0];
    assign data_o         = r_rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        ack_o    = 1'b0;
        err_o    = 1'b0;
        busy_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cs_i) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                busy_o = 1'b1;
                if (r_count == '0) begin
                    w_access = 1'b1;
                    w_next   = ACK;
                end
            end
            ACK: begin
                // cs_i is deliberately ignored here so a held request is only re-accepted from IDLE
                busy_o = 1'b1;
                ack_o  = 1'b1;
                err_o  = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= we_i;
                r_idx   <= addr_i[addr_width-1:offset_bits];
                r_wdata <= data_i;
                r_count <= CNT_W'(DLY - 1);
            end else if (r_state == BUSY && r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_access) begin
                r_err <= !w_inRange;
                if (!r_we) begin
                    r_rdata <= w_inRange ? r_mem[w_memAddr] : '0;
                end
            end
        end
    end

    // The array is never reset; an aborted request cannot write because reset forces IDLE.
    always_ff @(posedge clk_i) begin
        if (w_access && r_we && w_inRange) begin
            r_mem[w_memAddr] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: the driver queues expected responses,
// an independent monitor checks every ack against the queue head.
module tb_dram_responder;

    localparam int DELAY = 10;

    logic         clk   = 1'b0;
    logic         rstN  = 1'b1;
    logic         cs    = 1'b0;
    logic         we    = 1'b0;
    logic [31:0]  addr  = '0;
    logic [255:0] wdata = '0;
    logic         ack;
    logic         err;
    logic         busy;
    logic [255:0] rdata;

    typedef struct {
        logic [255:0] data;
        logic         err;
        int           ackEdge;
        string        name;
    } exp_t;

    exp_t expQ[$];
    int   edgeCount = 0;
    int   nChecks   = 0;
    int   nFail     = 0;

    localparam logic [255:0] PAT_A5  = {32{8'hA5}};
    localparam logic [255:0] PAT_5   = 256'h5;
    localparam logic [255:0] PAT_P1  = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_FF  = {32{8'hFF}};
    localparam logic [255:0] PAT_OLD = {8{32'h33333333}};
    localparam logic [255:0] PAT_NEW = {8{32'hCAFEF00D}};
    localparam logic [255:0] PAT_X   = {8{32'h12345678}};
    localparam logic [255:0] PAT_Y   = {8{32'h87654321}};
    localparam logic [255:0] PAT_Z   = {8{32'h0F0F0F0F}};

    dram_responder dut (
        .clk_i (clk),
        .rst_i (rstN),
        .cs_i  (cs),
        .we_i  (we),
        .addr_i(addr),
        .data_i(wdata),
        .ack_o (ack),
        .data_o(rdata),
        .err_o (err),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    exp_t monExp;
    always @(negedge clk) begin
        if (rstN && ack) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected_ack: got ack at edge %0d, expected none", edgeCount);
            end else begin
                monExp = expQ.pop_front();
                checkOutput({monExp.name, "_edge"}, 256'(edgeCount), 256'(monExp.ackEdge));
                checkOutput({monExp.name, "_err"}, 256'(err), 256'(monExp.err));
                checkOutput({monExp.name, "_data"}, rdata, monExp.data);
            end
        end
    end

    task automatic applyStimulus(input logic weIn, input logic [31:0] addrIn, input logic [255:0] dataIn,
                                 input logic [255:0] expData, input logic expErr, input int acceptEdge,
                                 input string name);
        cs    = 1'b1;
        we    = weIn;
        addr  = addrIn;
        wdata = dataIn;
        expQ.push_back('{data: expData, err: expErr, ackEdge: acceptEdge + DELAY, name: name});
    endtask

    task automatic waitAck(input string name, output int ackEdge);
        bit found;
        found   = 1'b0;
        ackEdge = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ack) begin
                found   = 1'b1;
                ackEdge = edgeCount;
            end
        end
        if (!found) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s_timeout: got no ack within 40 cycles, expected one", name);
        end
    endtask

    // Single request from IDLE; returns with the DUT back in IDLE
    task automatic doRequest(input logic weIn, input logic [31:0] addrIn, input logic [255:0] dataIn,
                             input logic [255:0] expData, input logic expErr, input string name);
        int a;
        applyStimulus(weIn, addrIn, dataIn, expData, expErr, edgeCount + 1, name);
        @(negedge clk);
        checkOutput({name, "_busy"}, 256'(busy), 256'(1));
        waitAck(name, a);
        cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a;
        int b;

        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("reset_ack", 256'(ack), 256'(0));
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_err", 256'(err), 256'(0));
        checkOutput("reset_data", rdata, '0);

        doRequest(1'b1, 32'h0400, PAT_A5, '0, 1'b0, "wr400");
        doRequest(1'b0, 32'h0400, '0, PAT_A5, 1'b0, "rd400");

        doRequest(1'b1, 32'h0000, PAT_5, PAT_A5, 1'b0, "wr0");
        doRequest(1'b0, 32'h0000, '0, PAT_5, 1'b0, "rd0");
        doRequest(1'b0, 32'h001F, '0, PAT_5, 1'b0, "rd1F");

        // Back-to-back: cs stays high across the first ack
        applyStimulus(1'b1, 32'h0040, PAT_P1, PAT_5, 1'b0, edgeCount + 1, "b2b_wr40");
        waitAck("b2b_wr40", a);
        applyStimulus(1'b0, 32'h0040, '0, PAT_P1, 1'b0, a + 2, "b2b_rd40");
        waitAck("b2b_rd40", b);
        cs = 1'b0;
        checkOutput("b2b_spacing", 256'(b - a), 256'(DELAY + 2));
        @(negedge clk);

        doRequest(1'b0, 32'h0001_0000, '0, '0, 1'b1, "rd_oor");
        doRequest(1'b1, 32'h0001_0000, PAT_FF, '0, 1'b1, "wr_oor");
        doRequest(1'b0, 32'h0000, '0, PAT_5, 1'b0, "rd0_after_oor");

        // Abort a write to block 3 with reset in the middle of BUSY
        doRequest(1'b1, 32'h0060, PAT_OLD, PAT_5, 1'b0, "wr60_old");
        cs    = 1'b1;
        we    = 1'b1;
        addr  = 32'h0060;
        wdata = PAT_NEW;
        repeat (5) @(negedge clk);
        checkOutput("abort_busy_before", 256'(busy), 256'(1));
        rstN = 1'b0;
        cs   = 1'b0;
        @(negedge clk);
        checkOutput("abort_ack", 256'(ack), 256'(0));
        checkOutput("abort_busy", 256'(busy), 256'(0));
        checkOutput("abort_data", rdata, '0);
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        doRequest(1'b0, 32'h0060, '0, PAT_OLD, 1'b0, "rd60_after_abort");

        // Inputs change and cs drops while BUSY; latched values must win
        doRequest(1'b1, 32'h00A0, PAT_Z, PAT_OLD, 1'b0, "wrA0");
        applyStimulus(1'b1, 32'h0080, PAT_X, PAT_OLD, 1'b0, edgeCount + 1, "wr80_latched");
        repeat (3) @(negedge clk);
        addr  = 32'h00A0;
        wdata = PAT_Y;
        repeat (2) @(negedge clk);
        cs = 1'b0;
        waitAck("wr80_latched", a);
        repeat (15) @(negedge clk);
        doRequest(1'b0, 32'h0080, '0, PAT_X, 1'b0, "rd80");
        doRequest(1'b0, 32'h00A0, '0, PAT_Z, 1'b0, "rdA0");

        repeat (15) @(negedge clk);
        checkOutput("queue_drained", 256'(expQ.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
Synthesizable responder end of the CPU/L1-cache external-memory handshake (cs/we/addr/data in, ack/data out). Accepts one block-sized read or write request at a time and holds it for a programmable latency. Performs the access on a local block array and returns a single-cycle ack. Drop-in replacement for the behavioural external memory on the CPU's mem_* port.

Parameters:
data_width, 256, block width in bits (one cache line)
mem_size, 2048, number of blocks in the array
delay, 10, cycles from request acceptance to ack (values <1 treated as 1)
addr_width, 32, byte-address width
offset_bits, 5, log2(data_width/8); block index = addr_i[addr_width-1:offset_bits]

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-low reset
cs_i  input  1  request valid; initiator holds it high, with addr/data/we stable, until it sees ack
we_i  input  1  1 = write block, 0 = read block
addr_i  input  addr_width  byte address of block
data_i  input  data_width  write data
ack_o  output  1  one-cycle completion pulse
data_o  output  data_width  read data, valid when ack_o=1 for a read
err_o  output  1  pulses with ack_o when block index >= mem_size
busy_o  output  1  high in BUSY and ACK states

Behaviour:
- Reset (rst_i=0, async): state IDLE; ack_o=0, err_o=0, busy_o=0, data_o=0, counter=0. Array contents not cleared. A request in flight is aborted: no write, no ack.
- States: IDLE, BUSY, ACK.
- IDLE: at an edge with cs_i=1, latch we_i, addr_i index and data_i; load counter=delay-1; go BUSY. With cs_i=0, stay IDLE.
- BUSY: input changes are ignored, because the latched copy is used. Each edge with counter!=0 decrements counter. At the edge with counter==0, perform the access and go ACK:
  - Write: array[idx] <= latched data.
  - Read: data_o <= array[idx].
  - Out of range (idx>=mem_size): write dropped, read returns data_o=0, err flag set.
- Latency: ack_o is high for exactly the cycle that begins delay edges after the accepting edge (delay=10: accept at edge N, ack during cycle after edge N+10).
- ACK: ack_o=1 and err_o=flag for one cycle, then unconditionally return to IDLE. cs_i is not sampled in ACK.
- Back-to-back requests: if cs_i is still high in the IDLE cycle after ACK, it is a new request. Minimum spacing is one IDLE cycle, so the throughput is one request per delay+2 cycles.
- data_o holds its value until the next read completes. Writes do not modify data_o.
- Index is addr_i[addr_width-1:offset_bits]; the low offset bits are ignored.
- cs_i dropped while in BUSY: the access still completes and ack still pulses (no cancel).

Test Plan:
- Reset with delay=10: hold rst_i=0, then release -> ack_o=0, busy_o=0, data_o=0. Then write 256'hA5..A5 to 0x0400 and read 0x0400 -> read ack exactly 10 edges after acceptance, data_o=256'hA5..A5, err_o=0.
- Preload array[0]=256'h5 and read address 0x0000 -> data_o=256'h5. Read 0x001F (offset bits set) -> same block, data_o=256'h5.
- Write 0x0040, then hold cs_i high continuously for a read of 0x0040 -> second request accepted in the IDLE cycle after the first ack. Read data equals the written data, and acks are 12 cycles apart.
- Out of range: read address 2048*32=0x10000 -> ack with err_o=1, data_o=0. Write to it, then read block 0 -> block 0 unchanged.
- Abort: assert rst_i=0 at cycle 5 of a write to 0x0060 -> no ack, array[3] keeps its old value. A request after reset completes normally.
- Input changes while BUSY: change addr_i and data_i mid-request -> the access uses the values latched at acceptance. Also drop cs_i mid-BUSY -> a single ack is still issued.
